// File: rtl/mem_pkg.sv
// Shared types for the M-stage data-memory access unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    // Default number of WAIT cycles before an unanswered access aborts.
    localparam int TIMEOUT_DEF = 15;

    // Load/store size in RISC-V funct3 encoding.
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks the byte/half at the byte offset and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: word (read word), offset (addr[1:0]), size (funct3), data (extended result).
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = word[{offset, 3'b000} +: 8];
    assign sel_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (size)
            SZ_B:    data = {{24{sel_byte[7]}}, sel_byte};
            SZ_H:    data = {{16{sel_half[15]}}, sel_half};
            SZ_BU:   data = {24'h0, sel_byte};
            SZ_HU:   data = {16'h0, sel_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// M-stage data-memory access: word-aligned req/ack transaction with byte strobes and load extension.
// Latency: request issued combinationally in IDLE; result presented in RESP, one cycle after ack.
// Backpressure: stall_M holds the pipeline from issue until ack or timeout; misaligned accesses never stall.
// Ports: memWrite_M/memRead_M/R_size_M/DMem_size_M/ALUResult_M/writeData_M from M stage;
//        dmem_req/we/addr/wdata/wstrb/ack/rdata to memory; readData_M/stall_M/misalign_M/busErr_M to pipeline.
module data_mem_access
    import mem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memWrite_M,
    input  logic             memRead_M,
    input  logic [2:0]       R_size_M,
    input  logic [2:0]       DMem_size_M,
    input  logic [WIDTH-1:0] ALUResult_M,
    input  logic [WIDTH-1:0] writeData_M,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] readData_M,
    output logic             stall_M,
    output logic             misalign_M,
    output logic             busErr_M
);

    // The last WAIT cycle that may still wait is TIMEOUT-1 on the counter.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mem_state_t       state, state_nxt;
    logic [7:0]       wait_cnt;
    logic [WIDTH-1:0] addr_q, wdata_q, cap_q;
    logic [3:0]       wstrb_q;
    logic             we_q;
    logic [1:0]       off_q;
    logic [2:0]       size_q;

    logic             access, is_store, misal, issue, timeout_hit, cap_store;
    logic [2:0]       size_in;
    logic [WIDTH-1:0] st_wdata, req_wdata, la_data;
    logic [3:0]       st_wstrb, req_wstrb;
    logic [1:0]       la_off;
    logic [2:0]       la_size;
    logic             unused_size_bit;

    // Stores only carry size in the low two bits.
    assign unused_size_bit = DMem_size_M[2];

    // Gated by rst so the block is quiet while held in reset.
    assign access   = rst & (memRead_M | memWrite_M);
    assign is_store = memWrite_M;
    assign size_in  = is_store ? {1'b0, DMem_size_M[1:0]} : R_size_M;

    // size[1] covers word (and undefined 11), which needs both low bits clear.
    assign misal = ((size_in[1:0] == 2'b01) & ALUResult_M[0]) |
                   (size_in[1] & (|ALUResult_M[1:0]));

    assign issue = (state == IDLE) & access & ~misal;

    assign timeout_hit = (state == WAIT) & ~dmem_ack & (wait_cnt == TO_LAST);

    // Store lane placement: sub-word data is replicated so every lane carries it.
    always_comb begin
        st_wdata = writeData_M;
        st_wstrb = 4'b1111;
        case (size_in[1:0])
            2'b00: begin
                st_wdata = {4{writeData_M[7:0]}};
                st_wstrb = 4'b0001 << ALUResult_M[1:0];
            end
            2'b01: begin
                st_wdata = {2{writeData_M[15:0]}};
                st_wstrb = 4'b0011 << {ALUResult_M[1], 1'b0};
            end
            default: ;
        endcase
    end

    assign req_wdata = is_store ? st_wdata : '0;
    assign req_wstrb = is_store ? st_wstrb : 4'b0000;

    // One aligner serves both the same-cycle ack in IDLE and acks in WAIT.
    assign la_off    = (state == IDLE) ? ALUResult_M[1:0] : off_q;
    assign la_size   = (state == IDLE) ? size_in : size_q;
    assign cap_store = (state == IDLE) ? is_store : we_q;

    load_align u_load_align (
        .word   (dmem_rdata),
        .offset (la_off),
        .size   (la_size),
        .data   (la_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = dmem_ack ? RESP : WAIT;
            WAIT:    if (dmem_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = 4'b0000;
        readData_M = '0;
        stall_M    = 1'b0;
        misalign_M = 1'b0;
        busErr_M   = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    misalign_M = access & misal;
                    if (issue) begin
                        dmem_req   = 1'b1;
                        dmem_we    = is_store;
                        dmem_addr  = {ALUResult_M[WIDTH-1:2], 2'b00};
                        dmem_wdata = req_wdata;
                        dmem_wstrb = req_wstrb;
                        stall_M    = 1'b1;
                    end
                end
                WAIT: begin
                    dmem_req   = 1'b1;
                    dmem_we    = we_q;
                    dmem_addr  = addr_q;
                    dmem_wdata = wdata_q;
                    dmem_wstrb = wstrb_q;
                    stall_M    = 1'b1;
                    busErr_M   = timeout_hit;
                end
                RESP:    readData_M = cap_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= 4'b0000;
            we_q     <= 1'b0;
            off_q    <= 2'b00;
            size_q   <= 3'b000;
            cap_q    <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                addr_q  <= {ALUResult_M[WIDTH-1:2], 2'b00};
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                we_q    <= is_store;
                off_q   <= ALUResult_M[1:0];
                size_q  <= size_in;
            end
            if (state == WAIT && !dmem_ack)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
            if ((issue || state == WAIT) && dmem_ack)
                cap_q <= cap_store ? '0 : la_data;
            else if (timeout_hit)
                cap_q <= '0;
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: store lanes, load extension, wait/stall length,
// misalignment, timeout and reset abandonment, with hand-computed expectations.
module tb_data_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        memWrite_M, memRead_M;
    logic [2:0]  R_size_M, DMem_size_M;
    logic [31:0] ALUResult_M, writeData_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata, readData_M;
    logic        stall_M, misalign_M, busErr_M;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_access #(.WIDTH(32), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .memWrite_M  (memWrite_M),
        .memRead_M   (memRead_M),
        .R_size_M    (R_size_M),
        .DMem_size_M (DMem_size_M),
        .ALUResult_M (ALUResult_M),
        .writeData_M (writeData_M),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .readData_M  (readData_M),
        .stall_M     (stall_M),
        .misalign_M  (misalign_M),
        .busErr_M    (busErr_M)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".req"},   {31'b0, dmem_req},   32'd0);
        chk({tag, ".we"},    {31'b0, dmem_we},    32'd0);
        chk({tag, ".addr"},  dmem_addr,           32'd0);
        chk({tag, ".wdata"}, dmem_wdata,          32'd0);
        chk({tag, ".wstrb"}, {28'b0, dmem_wstrb}, 32'd0);
        chk({tag, ".rdata"}, readData_M,          32'd0);
        chk({tag, ".stall"}, {31'b0, stall_M},    32'd0);
        chk({tag, ".mis"},   {31'b0, misalign_M}, 32'd0);
        chk({tag, ".berr"},  {31'b0, busErr_M},   32'd0);
    endtask

    // Drives ack in cycle 'waits' (0 = issue cycle), counts stall cycles and
    // busErr pulses, and returns readData_M sampled in the first unstalled cycle.
    task automatic run_acc(input int waits, input logic [31:0] rd,
                           output int stalls, output int err_at, output int err_cnt,
                           output logic [31:0] rdout, output logic done);
        stalls  = 0;
        err_at  = -1;
        err_cnt = 0;
        rdout   = 32'hxxxxxxxx;
        done    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            dmem_ack   = (i == waits);
            dmem_rdata = (i == waits) ? rd : 32'h5A5A5A5A;
            @(negedge clk);
            if (busErr_M) begin
                err_cnt++;
                err_at = i;
            end
            if (!stall_M) begin
                rdout = readData_M;
                done  = 1'b1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    // Load vectors against memory word 0x80FF1234 at 0x100.
    logic [2:0]  ld_sz   [5] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b010};
    logic [31:0] ld_addr [5] = '{32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
    int          ld_wait [5] = '{3, 1, 0, 2, 4};
    logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h000080FF, 32'hFFFF80FF,
                                 32'h00000012, 32'h80FF1234};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st, ea, ec;
        logic [31:0] rd;
        logic        dn;

        rst = 1'b0;
        memWrite_M = 1'b0; memRead_M = 1'b0;
        R_size_M = 3'b000; DMem_size_M = 3'b000;
        ALUResult_M = 32'h0; writeData_M = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b1;
        next_cyc;

        // SW 0xDEADBEEF @0x100, ack in issue cycle
        memWrite_M = 1'b1; DMem_size_M = 3'b010;
        ALUResult_M = 32'h100; writeData_M = 32'hDEADBEEF;
        #1;
        chk("sw.req",   {31'b0, dmem_req},   32'd1);
        chk("sw.we",    {31'b0, dmem_we},    32'd1);
        chk("sw.addr",  dmem_addr,           32'h100);
        chk("sw.wstrb", {28'b0, dmem_wstrb}, 32'hF);
        chk("sw.wdata", dmem_wdata,          32'hDEADBEEF);
        run_acc(0, 32'h0, st, ea, ec, rd, dn);
        chk("sw.done",     {31'b0, dn},       32'd1);
        chk("sw.stall",    st,                32'd1);
        chk("sw.resp.req", {31'b0, dmem_req}, 32'd0);
        next_cyc;
        memWrite_M = 1'b0;
        #1;
        chk("sw.idle.req", {31'b0, dmem_req}, 32'd0);

        // SB 0xA5 @0x103, one wait cycle; WAIT must replay registered copies
        memWrite_M = 1'b1; DMem_size_M = 3'b000;
        ALUResult_M = 32'h103; writeData_M = 32'h123456A5;
        #1;
        chk("sb.wstrb", {28'b0, dmem_wstrb}, 32'h8);
        chk("sb.wdata", dmem_wdata,          32'hA5A5A5A5);
        chk("sb.addr",  dmem_addr,           32'h100);
        next_cyc;
        chk("sb.w.req",   {31'b0, dmem_req},   32'd1);
        chk("sb.w.we",    {31'b0, dmem_we},    32'd1);
        chk("sb.w.wstrb", {28'b0, dmem_wstrb}, 32'h8);
        chk("sb.w.wdata", dmem_wdata,          32'hA5A5A5A5);
        chk("sb.w.addr",  dmem_addr,           32'h100);
        run_acc(0, 32'h0, st, ea, ec, rd, dn);
        chk("sb.stall", st, 32'd1);
        next_cyc;
        memWrite_M = 1'b0;

        // Loads: lane select, extension, stall length = waits + 1
        for (int k = 0; k < 5; k++) begin
            memRead_M = 1'b1; R_size_M = ld_sz[k]; ALUResult_M = ld_addr[k];
            #1;
            chk("ld.req",   {31'b0, dmem_req},   32'd1);
            chk("ld.we",    {31'b0, dmem_we},    32'd0);
            chk("ld.addr",  dmem_addr,           32'h100);
            chk("ld.wstrb", {28'b0, dmem_wstrb}, 32'h0);
            run_acc(ld_wait[k], 32'h80FF1234, st, ea, ec, rd, dn);
            chk("ld.done",  {31'b0, dn}, 32'd1);
            chk("ld.stall", st,          ld_wait[k] + 1);
            chk("ld.data",  rd,          ld_exp[k]);
            next_cyc;
            memRead_M = 1'b0;
        end

        // Misaligned LW @0x102
        memRead_M = 1'b1; R_size_M = 3'b010; ALUResult_M = 32'h102;
        #1;
        chk("mis.lw.flag",  {31'b0, misalign_M}, 32'd1);
        chk("mis.lw.req",   {31'b0, dmem_req},   32'd0);
        chk("mis.lw.stall", {31'b0, stall_M},    32'd0);
        chk("mis.lw.data",  readData_M,          32'd0);
        next_cyc;
        memRead_M = 1'b0;
        #1;
        chk("mis.lw.clear", {31'b0, misalign_M}, 32'd0);

        // Misaligned SH @0x101: store suppressed
        memWrite_M = 1'b1; DMem_size_M = 3'b001; ALUResult_M = 32'h101;
        writeData_M = 32'h0000BEEF;
        #1;
        chk("mis.sh.flag",  {31'b0, misalign_M}, 32'd1);
        chk("mis.sh.req",   {31'b0, dmem_req},   32'd0);
        chk("mis.sh.we",    {31'b0, dmem_we},    32'd0);
        chk("mis.sh.wstrb", {28'b0, dmem_wstrb}, 32'h0);
        next_cyc;
        memWrite_M = 1'b0;

        // SH @0x102: upper-half strobes, replicated half
        memWrite_M = 1'b1; DMem_size_M = 3'b001; ALUResult_M = 32'h102;
        writeData_M = 32'hFFFFBEEF;
        #1;
        chk("sh.wstrb", {28'b0, dmem_wstrb}, 32'hC);
        chk("sh.wdata", dmem_wdata,          32'hBEEFBEEF);
        run_acc(0, 32'h0, st, ea, ec, rd, dn);
        next_cyc;
        memWrite_M = 1'b0;

        // LW with no ack: timeout on the 15th WAIT cycle, data forced to 0
        memRead_M = 1'b1; R_size_M = 3'b010; ALUResult_M = 32'h200;
        #1;
        run_acc(1000, 32'h0, st, ea, ec, rd, dn);
        chk("to.done",   {31'b0, dn}, 32'd1);
        chk("to.stall",  st,          32'd16);
        chk("to.err_at", ea,          32'd15);
        chk("to.err_n",  ec,          32'd1);
        chk("to.data",   rd,          32'd0);
        next_cyc;
        memRead_M = 1'b0;

        // Reset in the middle of WAIT, then a late ack
        memRead_M = 1'b1; R_size_M = 3'b010; ALUResult_M = 32'h300;
        dmem_ack = 1'b0;
        next_cyc;
        next_cyc;
        chk("rw.pre.stall", {31'b0, stall_M},  32'd1);
        chk("rw.pre.req",   {31'b0, dmem_req}, 32'd1);
        rst = 1'b0;
        memRead_M = 1'b0;
        next_cyc;
        chk_quiet("rw.rst");
        rst = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        chk("rw.late.req",   {31'b0, dmem_req}, 32'd0);
        chk("rw.late.stall", {31'b0, stall_M},  32'd0);
        next_cyc;
        dmem_ack = 1'b0;
        #1;
        chk("rw.after.data",  readData_M,         32'd0);
        chk("rw.after.stall", {31'b0, stall_M},   32'd0);
        chk("rw.after.req",   {31'b0, dmem_req},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
